// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings,
// FSM states and the default datapath width.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the issue stage and the mul/div unit.
interface muldiv_if import muldiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;
    logic [4:0]       rd_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [4:0]       rd_out;
    logic             err;

    modport master (
        output start, funct3, rs1_val, rs2_val, rd_in,
        input  busy, done, result, rd_out, err
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val, rd_in,
        output busy, done, result, rd_out, err
    );
endinterface

// File: rtl/muldiv_divider.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step,
// dividend shifted out of the quotient register as quotient bits shift in.
module muldiv_divider import muldiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    assign trial = {remainder, quotient[WIDTH-1]};
    // MSB of diff set means trial < divisor: restore (keep trial)
    assign diff  = trial - {1'b0, dvs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
            dvs       <= '0;
        end else if (load) begin
            quotient  <= dividend;
            remainder <= '0;
            dvs       <= divisor;
        end else if (step) begin
            if (!diff[WIDTH]) begin
                remainder <= diff[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end else begin
                remainder <= trial[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Divide ops exist only when
// MULDIV_DIV_EN is defined; otherwise they complete at once with err=1.
module muldiv_unit import muldiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_e             state, state_nx;
    op_e                op;
    logic [WIDTH-1:0]   a, b, res;
    logic [4:0]         rd, rd_q;
    logic               res_err;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod, prod_s;

    logic             a_neg, b_neg, neg, is_div, shortcut, short_err;
    logic [WIDTH-1:0] a_mag, b_mag, fix_res, short_res;
    logic [WIDTH:0]   mul_sum;

    // Operands and op stay latched for the whole op, so signs are derived live
    assign is_div  = op[2];
    assign a_neg   = a[WIDTH-1] & (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
    assign b_neg   = b[WIDTH-1] & (op == OP_MULH || op == OP_DIV || op == OP_REM);
    assign neg     = a_neg ^ b_neg;
    assign a_mag   = a_neg ? ~a + 1'b1 : a;
    assign b_mag   = b_neg ? ~b + 1'b1 : b;
    assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, a_mag};
    assign prod_s  = neg ? ~prod + 1'b1 : prod;

`ifdef MULDIV_DIV_EN
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] quo, rem, quo_s, rem_s;

    assign div_zero  = (b == '0);
    assign div_ovf   = (op == OP_DIV || op == OP_REM) && a == MIN_NEG && b == '1;
    assign shortcut  = is_div && (div_zero || div_ovf);
    assign short_res = op[1] ? (div_zero ? a : '0) : (div_zero ? '1 : MIN_NEG);
    assign short_err = 1'b0;

    muldiv_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (state == S_PREP && is_div),
        .step      (state == S_ITER && is_div),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem)
    );

    // Remainder takes the dividend's sign, quotient truncates toward zero
    assign quo_s   = neg ? ~quo + 1'b1 : quo;
    assign rem_s   = a_neg ? ~rem + 1'b1 : rem;
    assign fix_res = is_div ? (op[1] ? rem_s : quo_s)
                   : (op == OP_MUL ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH]);
`else
    assign shortcut  = is_div;
    assign short_res = '0;
    assign short_err = 1'b1;
    assign fix_res   = (op == OP_MUL) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_PREP;
            S_PREP:  state_nx = shortcut ? S_DONE : S_ITER;
            S_ITER:  if (cnt == CW'(WIDTH-1)) state_nx = S_FIX;
            S_FIX:   state_nx = S_DONE;
            S_DONE:  state_nx = bus.start ? S_PREP : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op      <= OP_MUL;
            a       <= '0;
            b       <= '0;
            rd      <= '0;
            cnt     <= '0;
            prod    <= '0;
            res     <= '0;
            res_err <= 1'b0;
            rd_q    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE, S_DONE: if (bus.start) begin
                    a  <= bus.rs1_val;
                    b  <= bus.rs2_val;
                    op <= op_e'(bus.funct3);
                    rd <= bus.rd_in;
                end
                S_PREP: begin
                    cnt  <= '0;
                    prod <= {{WIDTH{1'b0}}, b_mag};
                    if (shortcut) begin
                        res     <= short_res;
                        res_err <= short_err;
                        rd_q    <= rd;
                    end
                end
                S_ITER: begin
                    cnt <= cnt + 1'b1;
                    // Shift-add: multiplier bits leave the low half as product bits enter the top
                    if (!is_div)
                        prod <= prod[0] ? {mul_sum, prod[WIDTH-1:1]} : {1'b0, prod[2*WIDTH-1:1]};
                end
                S_FIX: begin
                    res     <= fix_res;
                    res_err <= 1'b0;
                    rd_q    <= rd;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state == S_PREP) || (state == S_ITER) || (state == S_FIX);
    assign bus.done   = (state == S_DONE);
    assign bus.result = res;
    assign bus.rd_out = rd_q;
    assign bus.err    = res_err;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops
// against an arithmetic reference model, plus mid-op start and reset sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int LAT_ITER = 35;
    localparam int LAT_FAST = 2;
    localparam int LAT_LIMIT = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus();
    muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(string n, logic [2:0] f, logic [31:0] a, logic [31:0] b,
                                logic [4:0] rd, logic [31:0] res, logic err, int lat);
        vec_t v;
        v.name = n; v.f = f; v.a = a; v.b = b; v.rd = rd;
        v.res = res; v.err = err; v.lat = lat;
        return v;
    endfunction

    // Divide expectations collapse to result 0 / err 1 / fast completion without the divider
    function automatic vec_t mkd(string n, logic [2:0] f, logic [31:0] a, logic [31:0] b,
                                 logic [4:0] rd, logic [31:0] res, int lat);
        return mk(n, f, a, b, rd, DIV_EN ? res : 32'h0, !DIV_EN, DIV_EN ? lat : LAT_FAST);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic void model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e, output int lat);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        e = 1'b0; lat = LAT_ITER; r = '0; p = '0;
        case (f)
            3'b000: begin p = sa * sb; r = p[31:0]; end
            3'b001: begin p = sa * sb; r = p[63:32]; end
            3'b010: begin p = sa * ub; r = p[63:32]; end
            3'b011: begin p = ua * ub; r = p[63:32]; end
            default: begin
                if (!DIV_EN) begin
                    e = 1'b1; lat = LAT_FAST;
                end else if (b == 32'h0) begin
                    lat = LAT_FAST; r = f[1] ? a : 32'hFFFF_FFFF;
                end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lat = LAT_FAST; r = f[1] ? 32'h0 : 32'h8000_0000;
                end else if (f[0]) begin
                    r = f[1] ? a % b : a / b;
                end else begin
                    r = f[1] ? 32'(sa % sb) : 32'(sa / sb);
                end
            end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or on timeout)
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat);
        bus.start = 1'b1; bus.funct3 = f; bus.rs1_val = a; bus.rs2_val = b; bus.rd_in = rd;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && lat < LAT_LIMIT) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, dones;
        logic [31:0] er, ea, eb;
        logic ee;
        logic [2:0] ef;
        logic [4:0] erd;

        vecs.push_back(mk ("mul_7x-3",   3'b000, 32'h7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0, LAT_ITER));
        vecs.push_back(mk ("mulhu_ff",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 1'b0, LAT_ITER));
        vecs.push_back(mk ("mulh_ff",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 1'b0, LAT_ITER));
        vecs.push_back(mk ("mulhsu_ff",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 1'b0, LAT_ITER));
        vecs.push_back(mk ("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd9,  32'h4000_0000, 1'b0, LAT_ITER));
        vecs.push_back(mkd("div_-7/2",   3'b100, 32'hFFFF_FFF9, 32'h2,         5'd10, 32'hFFFF_FFFD, LAT_ITER));
        vecs.push_back(mkd("rem_-7/2",   3'b110, 32'hFFFF_FFF9, 32'h2,         5'd11, 32'hFFFF_FFFF, LAT_ITER));
        vecs.push_back(mkd("divu_100/0", 3'b101, 32'd100,       32'h0,         5'd12, 32'hFFFF_FFFF, LAT_FAST));
        vecs.push_back(mkd("remu_100/0", 3'b111, 32'd100,       32'h0,         5'd13, 32'd100,       LAT_FAST));
        vecs.push_back(mkd("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, LAT_FAST));
        vecs.push_back(mkd("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0,         LAT_FAST));
        vecs.push_back(mkd("divu_10/3",  3'b101, 32'd10,        32'd3,         5'd16, 32'd3,         LAT_ITER));
        vecs.push_back(mkd("rem_7/-2",   3'b110, 32'd7,         32'hFFFF_FFFE, 5'd17, 32'd1,         LAT_ITER));
        vecs.push_back(mkd("remu_big",   3'b111, 32'hFFFF_FFFF, 32'h10,        5'd18, 32'hF,         LAT_ITER));

        bus.start = 1'b0; bus.funct3 = '0; bus.rs1_val = '0; bus.rs2_val = '0; bus.rd_in = '0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_result", bus.result, 32'h0);
        check("rst_rd_out", bus.rd_out, 5'h0);
        check("rst_err", bus.err, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, issued back to back (each start lands in the done cycle)
        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, lat);
            check({vecs[i].name, "_result"}, bus.result, vecs[i].res);
            check({vecs[i].name, "_err"}, bus.err, vecs[i].err);
            check({vecs[i].name, "_rd_out"}, bus.rd_out, vecs[i].rd);
            check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
        end

        // Result and rd_out hold after done while idle
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("hold_done", bus.done, 1'b0);
        check("hold_result", bus.result, vecs[vecs.size()-1].res);
        check("hold_rd_out", bus.rd_out, vecs[vecs.size()-1].rd);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            ef = 3'($urandom_range(0, 7));
            ea = pick();
            eb = pick();
            erd = 5'($urandom);
            model(ef, ea, eb, er, ee, lat);
            begin
                int got_lat;
                run_op(ef, ea, eb, erd, got_lat);
                check($sformatf("rand%0d_f%0d_result", i, ef), bus.result, er);
                check($sformatf("rand%0d_err", i), bus.err, ee);
                check($sformatf("rand%0d_rd_out", i), bus.rd_out, erd);
                check($sformatf("rand%0d_latency", i), got_lat, lat);
            end
        end

        // Second start mid-op must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.rs1_val = 32'd1234; bus.rs2_val = 32'd5678; bus.rd_in = 5'd7;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && lat < LAT_LIMIT) begin
            if (lat == 10) begin
                bus.start = 1'b1; bus.funct3 = 3'b011; bus.rs1_val = 32'hDEAD_BEEF;
                bus.rs2_val = 32'h1357_9BDF; bus.rd_in = 5'd9;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 12) check("midop_busy", bus.busy, 1'b1);
        end
        bus.start = 1'b0;
        check("midop_result", bus.result, 32'd7006652);
        check("midop_rd_out", bus.rd_out, 5'd7);
        check("midop_latency", lat, LAT_ITER);

        // Asynchronous reset in the middle of an op
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b011; bus.rs1_val = 32'hFFFF_FFFF; bus.rs2_val = 32'h2; bus.rd_in = 5'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_done", bus.done, 1'b0);
        check("midrst_result", bus.result, 32'h0);
        check("midrst_rd_out", bus.rd_out, 5'h0);
        check("midrst_err", bus.err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        check("midrst_no_activity", dones, 0);

        // Recovery after reset
        run_op(3'b000, 32'd6, 32'd7, 5'd21, lat);
        check("recover_result", bus.result, 32'd42);
        check("recover_rd_out", bus.rd_out, 5'd21);
        check("recover_latency", lat, LAT_ITER);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width and iteration count.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: start  input  1  request, sampled only when busy=0.
REQ-005 SHALL have port: funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port: rs1_val  input  WIDTH  operand A, from register unit ru_rs1.
REQ-007 SHALL have port: rs2_val  input  WIDTH  operand B, from register unit ru_rs2.
REQ-008 SHALL have port: rd_in  input  5  destination index, carried with the op.
REQ-009 SHALL have port: busy  output  1  op in flight.
REQ-010 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port: result  output  WIDTH  result, for register unit ru_data_wr.
REQ-012 SHALL have port: rd_out  output  5  captured rd_in, for register unit rd.
REQ-013 SHALL have port: err  output  1  op not supported in this build, valid with done.

Function
REQ-014 SHALL accept start when busy=0: latch operands, funct3, rd_in; busy=1 next cycle.
REQ-015 SHALL ignore start while busy=1; latched operands SHALL NOT change.
REQ-016 SHALL implement FSM IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
- PREP: take absolute values per signedness; record result sign.
- ITER: WIDTH iterations, one bit per cycle, 5-bit-plus counter.
- FIX: apply sign; select high/low half or quotient/remainder.
- DONE: done=1, busy=0 for exactly one cycle.
REQ-017 SHALL assert done exactly WIDTH+3 cycles after the start-sampling edge for iterative ops (35 at WIDTH=32).
REQ-018 SHALL compute MUL as low WIDTH bits, and MULH/MULHSU/MULHU as high WIDTH bits of the 2*WIDTH product (signed x signed, signed x unsigned, unsigned x unsigned).
REQ-019 SHALL implement division by zero as PREP -> DONE, with done 2 cycles after start, quotient all-ones, and remainder = rs1_val.
REQ-020 SHALL implement signed overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF) as PREP -> DONE, with quotient 0x80000000 and remainder 0.
REQ-021 SHALL give the remainder the sign of the dividend and truncate the quotient toward zero.
REQ-022 SHALL hold result and rd_out from DONE until the next accepted start.
REQ-023 SHALL accept start in the same cycle that done=1, since busy=0 then.

Reset
REQ-024 SHALL, on rst_n=0 and at any time including mid-op, asynchronously force IDLE, busy=0, done=0, err=0, result=0, rd_out=0 and the counter to 0.
REQ-025 SHALL accept no start before the first rising clk edge after rst_n deasserts.

Configuration
REQ-026 SHALL use macro MULDIV_DIV_EN.
- Defined: divide ops 100-111 as above, err=0.
- Undefined: no divider logic; divide ops go PREP -> DONE with result=0 and err=1; multiply ops unchanged.

Structure
REQ-027 SHALL put the funct3 encodings, FSM state typedef and WIDTH default in shared package muldiv_pkg.
REQ-028 SHALL put the restoring divide datapath in sub-module muldiv_divider, instantiated only under MULDIV_DIV_EN.

Verification
REQ-029 SHALL check: MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> result 0xFFFFFFEB, done at cycle 35, rd_out=rd_in.
REQ-030 SHALL check: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-031 SHALL check: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF with done at cycle 2.
REQ-032 SHALL check: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0, done at cycle 2.
REQ-033 SHALL check: second start pulsed mid-op -> ignored, first result intact; rst_n low at cycle 10 -> busy=0, result=0, no done.
REQ-034 SHALL check: build without MULDIV_DIV_EN, DIVU 10/3 -> result 0, err=1, done at cycle 2.
